// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants, FSM state type and a DIGITS sizing helper for the
// sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  // ceil(width * log10(2)) in fixed point; width*log10(2) is never an exact
  // integer for width > 0, so the rounding constant gives a true ceiling.
  function automatic int min_digits(input int width);
    longint num;
    num = longint'(width) * 64'sd301029995664;
    return int'((num + 64'sd999999999999) / 64'sd1000000000000);
  endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Single BCD nibble adjust: add 3 when the digit is 5 or more, wrapping
// inside the nibble.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] nib_i,
  output logic [DIGIT_W-1:0] nib_o
);

  always_comb begin
    nib_o = nib_i;
    if (nib_i >= ADJ_THRESH) begin
      nib_o = nib_i + ADJ_ADD;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Handshaked double-dabble binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blanking output enabled by BIN2BCD_LZ_BLANK_EN.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      data,
  output logic                  busy,
  output logic                  bcd_valid,
  output logic [4*DIGITS-1:0]   bcd_data,
  output logic                  bcd_ovf,
`ifdef BIN2BCD_LZ_BLANK_EN
  output logic [DIGITS-1:0]     digit_en,
`endif
  output logic                  dbg_state_o
);

  // Handshake: start is honoured only on an edge where busy is low; busy is
  // high for exactly BIN_W cycles after acceptance; bcd_valid pulses for one
  // cycle (with busy already low) when bcd_data/bcd_ovf have just been loaded.

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SR_W  = BIN_W + BCD_W;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_e             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               bcd_ovf_q, bcd_ovf_d;
  logic               valid_q, valid_d;

  logic [BCD_W-1:0]   adj_bcd;
  logic [SR_W-1:0]    adj_sr;
  logic [SR_W-1:0]    step_sr;
  logic [BCD_W-1:0]   step_bcd;
  logic               shift_out;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .nib_i (sr_q[BIN_W + DIGIT_W*g +: DIGIT_W]),
      .nib_o (adj_bcd[DIGIT_W*g +: DIGIT_W])
    );
  end

  // The bit leaving the top digit on a shift is the decimal carry that no
  // longer fits, which is what feeds the sticky overflow.
  assign adj_sr    = {adj_bcd, sr_q[BIN_W-1:0]};
  assign shift_out = adj_sr[SR_W-1];
  assign step_sr   = {adj_sr[SR_W-2:0], 1'b0};
  assign step_bcd  = step_sr[SR_W-1:BIN_W];

`ifdef BIN2BCD_LZ_BLANK_EN
  logic [DIGITS-1:0] lz_en;
  logic [DIGITS-1:0] den_q, den_d;

  always_comb begin
    logic seen;
    seen  = 1'b0;
    lz_en = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen     = seen | (step_bcd[DIGIT_W*i +: DIGIT_W] != '0);
      lz_en[i] = seen;
    end
    lz_en[0] = 1'b1;
  end
`endif

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    bcd_ovf_d = bcd_ovf_q;
    valid_d   = 1'b0;
`ifdef BIN2BCD_LZ_BLANK_EN
    den_d     = den_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {{BCD_W{1'b0}}, data};
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        sr_d  = step_sr;
        cnt_d = cnt_q + CNT_W'(1);
        ovf_d = ovf_q | shift_out;
        if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          valid_d   = 1'b1;
          bcd_d     = step_bcd;
          bcd_ovf_d = ovf_q | shift_out;
`ifdef BIN2BCD_LZ_BLANK_EN
          den_d     = lz_en;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      bcd_ovf_q <= 1'b0;
      valid_q   <= 1'b0;
`ifdef BIN2BCD_LZ_BLANK_EN
      den_q     <= DIGITS'(1);
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
      bcd_ovf_q <= bcd_ovf_d;
      valid_q   <= valid_d;
`ifdef BIN2BCD_LZ_BLANK_EN
      den_q     <= den_d;
`endif
    end
  end

  assign busy        = (state_q == CONV);
  assign bcd_valid   = valid_q;
  assign bcd_data    = bcd_q;
  assign bcd_ovf     = bcd_ovf_q;
  assign dbg_state_o = (state_q == CONV);
`ifdef BIN2BCD_LZ_BLANK_EN
  assign digit_en    = den_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: four instances (8/3, 32/10, 8/2, 16/5)
// checked against an arithmetic decimal model.
module tb_bin2bcd_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    logic [79:0] bcd;
    logic        ovf;
    logic [19:0] den;
    longint      acc;
  } exp_t;

  exp_t   exp_a[$], exp_b[$], exp_c[$], exp_d[$];
  longint vcyc_a[$];

  // ---------------- DUT signals ----------------
  logic        start_a = 0, start_b = 0, start_c = 0, start_d = 0;
  logic [7:0]  data_a = 0;
  logic [31:0] data_b = 0;
  logic [7:0]  data_c = 0;
  logic [15:0] data_d = 0;
  logic        busy_a, busy_b, busy_c, busy_d;
  logic        valid_a, valid_b, valid_c, valid_d;
  logic        ovf_a, ovf_b, ovf_c, ovf_d;
  logic        st_a, st_b, st_c, st_d;
  logic [11:0] bcd_a;
  logic [39:0] bcd_b;
  logic [7:0]  bcd_c;
  logic [19:0] bcd_d;
  logic [2:0]  den_a;
  logic [9:0]  den_b;
  logic [1:0]  den_c;
  logic [4:0]  den_d;

`ifndef BIN2BCD_LZ_BLANK_EN
  assign den_a = '0;
  assign den_b = '0;
  assign den_c = '0;
  assign den_d = '0;
`endif

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start_a), .data(data_a),
    .busy(busy_a), .bcd_valid(valid_a), .bcd_data(bcd_a), .bcd_ovf(ovf_a),
`ifdef BIN2BCD_LZ_BLANK_EN
    .digit_en(den_a),
`endif
    .dbg_state_o(st_a));

  bin2bcd_seq #(.BIN_W(32), .DIGITS(10)) u_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start_b), .data(data_b),
    .busy(busy_b), .bcd_valid(valid_b), .bcd_data(bcd_b), .bcd_ovf(ovf_b),
`ifdef BIN2BCD_LZ_BLANK_EN
    .digit_en(den_b),
`endif
    .dbg_state_o(st_b));

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_c (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start_c), .data(data_c),
    .busy(busy_c), .bcd_valid(valid_c), .bcd_data(bcd_c), .bcd_ovf(ovf_c),
`ifdef BIN2BCD_LZ_BLANK_EN
    .digit_en(den_c),
`endif
    .dbg_state_o(st_c));

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_d (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start_d), .data(data_d),
    .busy(busy_d), .bcd_valid(valid_d), .bcd_data(bcd_d), .bcd_ovf(ovf_d),
`ifdef BIN2BCD_LZ_BLANK_EN
    .digit_en(den_d),
`endif
    .dbg_state_o(st_d));

  // ---------------- reference model ----------------
  // Decimal digits of v mod 10^digits by repeated division; overflow when
  // v needs more than 'digits' decimal digits.
  function automatic exp_t make_exp(longint unsigned v, int digits, longint acc);
    exp_t e;
    longint unsigned p = 1;
    longint unsigned m;
    logic hi = 1'b0;
    for (int i = 0; i < digits; i++) p = p * 10;
    e.ovf = (v >= p);
    m = v % p;
    e.bcd = '0;
    e.den = '0;
    for (int i = 0; i < digits; i++) begin
      e.bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    for (int i = digits - 1; i >= 0; i--) begin
      if (e.bcd[4*i +: 4] != 4'd0) hi = 1'b1;
      e.den[i] = hi;
    end
    e.den[0] = 1'b1;
    e.acc = acc;
    return e;
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_errs++;
    $display("FAIL %s", nm);
  endtask

  task automatic check_out(input string nm, input exp_t e, input logic [79:0] bcd,
                           input logic ovf, input logic [19:0] den, input logic busy,
                           input longint now, input int bin_w);
    chk({nm, " bcd_data"}, bcd, e.bcd);
    chk({nm, " bcd_ovf"}, 80'(ovf), 80'(e.ovf));
    chk({nm, " latency"}, 80'(now - e.acc), 80'(bin_w));
    chk({nm, " busy at valid"}, 80'(busy), 80'(0));
`ifdef BIN2BCD_LZ_BLANK_EN
    chk({nm, " digit_en"}, 80'(den), 80'(e.den));
`endif
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (valid_a) begin
      if (exp_a.size() == 0) fail_now("A unexpected bcd_valid");
      else check_out("A", exp_a.pop_front(), 80'(bcd_a), ovf_a, 20'(den_a), busy_a, cyc, 8);
      vcyc_a.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (valid_b) begin
      if (exp_b.size() == 0) fail_now("B unexpected bcd_valid");
      else check_out("B", exp_b.pop_front(), 80'(bcd_b), ovf_b, 20'(den_b), busy_b, cyc, 32);
    end
  end

  always @(negedge clk) begin
    if (valid_c) begin
      if (exp_c.size() == 0) fail_now("C unexpected bcd_valid");
      else check_out("C", exp_c.pop_front(), 80'(bcd_c), ovf_c, 20'(den_c), busy_c, cyc, 8);
    end
  end

  always @(negedge clk) begin
    if (valid_d) begin
      if (exp_d.size() == 0) fail_now("D unexpected bcd_valid");
      else check_out("D", exp_d.pop_front(), 80'(bcd_d), ovf_d, 20'(den_d), busy_d, cyc, 16);
    end
  end

  // ---------------- drivers ----------------
  function automatic logic busy_of(input int sel);
    case (sel)
      0: return busy_a;
      1: return busy_b;
      2: return busy_c;
      default: return busy_d;
    endcase
  endfunction

  task automatic set_in(input int sel, input logic s, input longint unsigned v);
    case (sel)
      0: begin start_a = s; data_a = 8'(v); end
      1: begin start_b = s; data_b = 32'(v); end
      2: begin start_c = s; data_c = 8'(v); end
      default: begin start_d = s; data_d = 16'(v); end
    endcase
  endtask

  task automatic set_data(input int sel, input longint unsigned v);
    case (sel)
      0: data_a = 8'(v);
      1: data_b = 32'(v);
      2: data_c = 8'(v);
      default: data_d = 16'(v);
    endcase
  endtask

  task automatic set_start(input int sel, input logic s);
    case (sel)
      0: start_a = s;
      1: start_b = s;
      2: start_c = s;
      default: start_d = s;
    endcase
  endtask

  // Waits for busy low (scrambling data meanwhile), presents v, and leaves
  // start high afterwards when hold is set.
  task automatic send(input int sel, input longint unsigned v, input bit hold, input bit push);
    int guard = 0;
    @(negedge clk);
    while (busy_of(sel)) begin
      set_data(sel, longint'($urandom));
      guard++;
      if (guard > 200) begin
        fail_now("send busy timeout");
        return;
      end
      @(negedge clk);
    end
    set_in(sel, 1'b1, v);
    if (push) begin
      case (sel)
        0: exp_a.push_back(make_exp(v, 3, cyc + 1));
        1: exp_b.push_back(make_exp(v, 10, cyc + 1));
        2: exp_c.push_back(make_exp(v, 2, cyc + 1));
        default: exp_d.push_back(make_exp(v, 5, cyc + 1));
      endcase
    end
    @(negedge clk);
    if (!hold) set_start(sel, 1'b0);
    set_data(sel, longint'($urandom));
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_a.size() + exp_b.size() + exp_c.size() + exp_d.size()) != 0 ||
           busy_a || busy_b || busy_c || busy_d) begin
      @(negedge clk);
      g++;
      if (g > 3000) begin
        fail_now("drain timeout");
        return;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", 80'(busy_a), 80'(0));
    chk("reset bcd_valid", 80'(valid_a), 80'(0));
    chk("reset bcd_data", 80'(bcd_a), 80'(0));
    chk("reset bcd_ovf", 80'(ovf_a), 80'(0));
    chk("reset state", 80'(st_a), 80'(0));
    chk("reset B bcd_data", 80'(bcd_b), 80'(0));
`ifdef BIN2BCD_LZ_BLANK_EN
    chk("reset digit_en", 80'(den_a), 80'(1));
`endif
    rst_n = 1'b1;

    send(0, 255, 0, 1);
    drain();

    // start held high: mid-conversion starts ignored, second value taken
    // in the valid cycle, leaving BIN_W idle cycles between pulses.
    vcyc_a.delete();
    send(0, 12, 1, 1);
    send(0, 34, 0, 1);
    drain();
    chk("A b2b pulse count", 80'(vcyc_a.size()), 80'(2));
    if (vcyc_a.size() == 2) chk("A b2b pulse spacing", 80'(vcyc_a[1] - vcyc_a[0]), 80'(9));

    for (int i = 0; i < 20; i++) begin
      send(0, longint'($urandom_range(0, 255)), (i < 19) ? bit'($urandom_range(0, 1)) : 1'b0, 1);
    end
    drain();

    // reset during step 4 aborts without a result
    send(0, 200, 0, 1);
    drain();
    send(0, 77, 0, 0);
    repeat (3) @(negedge clk);
    chk("A busy mid conv", 80'(busy_a), 80'(1));
    chk("A state mid conv", 80'(st_a), 80'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk("A busy after abort", 80'(busy_a), 80'(0));
    chk("A bcd_data after abort", 80'(bcd_a), 80'(0));
    chk("A bcd_ovf after abort", 80'(ovf_a), 80'(0));
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send(0, 77, 0, 1);
    drain();

    send(1, 0, 0, 1);
    send(1, 64'd4294967295, 0, 1);
    for (int i = 0; i < 8; i++) send(1, longint'($urandom), 0, 1);
    drain();

    send(2, 100, 0, 1);
    send(2, 99, 0, 1);
    for (int i = 0; i < 15; i++) begin
      send(2, longint'($urandom_range(0, 255)), (i < 14) ? bit'($urandom_range(0, 1)) : 1'b0, 1);
    end
    drain();

    send(3, 305, 0, 1);
    send(3, 0, 0, 1);
    for (int i = 0; i < 8; i++) send(3, longint'($urandom_range(0, 65535)), 0, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
